rv_muldiv_unit: RTL and testbench

//   Parametrised RV32M/RV64M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

---
 rtl/rv_muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - RV32M/RV64M multiply/divide execute unit.
// One op in flight; multiplies use a fixed-latency path, divides a restoring radix-2^DIV_BITS loop.
module rv_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int NDIV = XLEN / DIV_BITS;
  localparam int CW   = $clog2(NDIV + MUL_STAGES + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DSP  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [4:0]      tag_q, tag_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  logic            accept, sgn_div, s1, s2, div0, ovf;
  logic [XLEN-1:0] abs1, abs2, special;
  logic            a_sgn, b_sgn;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res, quo_fix, rem_fix;
  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;

  assign valid_o  = (state_q == S_DONE);
  assign ready_o  = (state_q == S_IDLE) | valid_o;
  assign busy_o   = (state_q != S_IDLE) & ~valid_o;
  assign result_o = result_q;
  assign rd_o     = rd_q;
  assign accept   = valid_i & ready_o & ~flush_i;

  // Divide operand conditioning and the special cases are resolved at accept time.
  assign sgn_div = op_i[2] & ~op_i[0];
  assign s1      = rs1_i[XLEN-1];
  assign s2      = rs2_i[XLEN-1];
  assign abs1    = (sgn_div & s1) ? -rs1_i : rs1_i;
  assign abs2    = (sgn_div & s2) ? -rs2_i : rs2_i;
  assign div0    = (rs2_i == '0);
  assign ovf     = sgn_div & (rs1_i == MIN_NEG) & (rs2_i == '1);
  assign special = div0 ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);

  assign a_sgn   = (op_q == 2'b01) | (op_q == 2'b10);
  assign b_sgn   = (op_q == 2'b01);
  assign prod    = $signed({a_sgn & a_q[XLEN-1], a_q}) * $signed({b_sgn & b_q[XLEN-1], b_q});
  assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign quo_fix = neg_q ? -a_q : a_q;
  assign rem_fix = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  // a_q doubles as the quotient shift register: dividend bits leave the top, quotient bits enter below.
  always_comb begin
    r = rem_q;
    q = a_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, b_q}) begin
        r    = r - {1'b0, b_q};
        q[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    tag_d    = tag_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mul_res;
          rd_d     = tag_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DSP: begin
        state_d  = S_DONE;
        result_d = a_q;
        rd_d     = tag_q;
      end
      S_DIV: begin
        a_d   = q;
        rem_d = r;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d  = S_DONE;
        result_d = op_q[1] ? rem_fix : quo_fix;
        rd_d     = tag_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      op_d   = op_i[1:0];
      tag_d  = rd_i;
      rem_d  = '0;
      neg_d  = sgn_div & (s1 ^ s2);
      rneg_d = sgn_div & s1;
      if (!op_i[2]) begin
        state_d = S_MUL;
        cnt_d   = CW'(MUL_STAGES - 1);
        a_d     = rs1_i;
        b_d     = rs2_i;
      end else if (div0 | ovf) begin
        state_d = S_DSP;
        a_d     = special;
      end else begin
        state_d = S_DIV;
        cnt_d   = CW'(NDIV - 1);
        a_d     = abs1;
        b_d     = abs2;
      end
    end
    // An abandoned op must not disturb the held result.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_d     = rd_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - directed self-checking bench for rv_muldiv_unit.
// A second instance with DIV_BITS=4 covers the shortened divide latency.
module tb_rv_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, valid4, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        ready4_o, busy4_o, valid4_o;
  logic [31:0] result4_o;
  logic [4:0]  rd4_o;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) dut (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .flush_i(flush), .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o),
    .result_o(result_o), .rd_o(rd_o));

  rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid4), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .flush_i(flush), .ready_o(ready4_o), .busy_o(busy4_o), .valid_o(valid4_o),
    .result_o(result4_o), .rd_o(rd4_o));

  task automatic wait_result(output int lat, output logic [31:0] res, output logic [4:0] rdo);
    lat = -1; res = 'x; rdo = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (valid_o) begin lat = i; res = result_o; rdo = rd_o; break; end
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    @(negedge clk);
    valid = 1'b1; op = o; rs1 = a; rs2 = b; rd = t;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        output int lat, output logic [31:0] res, output logic [4:0] rdo);
    drive(o, a, b, t);
    wait_result(lat, res, rdo);
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++; if (rd_o !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] res; logic [4:0] t;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, lat, res, t);
    checks++; if (lat !== 2) begin failures++; $display("FAIL mul_lat got=%0d exp=2", lat); end
    checks++; if (res !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_res got=%h exp=FFFFFFEB", res); end
    checks++; if (t !== 5'd5) begin failures++; $display("FAIL mul_rd got=%0d exp=5", t); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL mul_pulse got=%b exp=0", valid_o); end
    checks++; if (result_o !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_hold got=%h exp=FFFFFFEB", result_o); end
    run_op(3'd0, 32'h00010000, 32'h00010000, 5'd6, lat, res, t);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL mul_low got=%h exp=0", res); end
    run_op(3'd3, 32'h00010000, 32'h00010000, 5'd7, lat, res, t);
    checks++; if (res !== 32'h1) begin failures++; $display("FAIL mulhu_small got=%h exp=1", res); end
  endtask

  task automatic test_mulh;
    int lat; logic [31:0] res; logic [4:0] t;
    run_op(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1, lat, res, t);
    checks++; if (res !== 32'h00000000) begin failures++; $display("FAIL mulh got=%h exp=00000000", res); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd2, lat, res, t);
    checks++; if (res !== 32'h80000000) begin failures++; $display("FAIL mulhsu got=%h exp=80000000", res); end
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd3, lat, res, t);
    checks++; if (res !== 32'h7FFFFFFF) begin failures++; $display("FAIL mulhu got=%h exp=7FFFFFFF", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL mulhu_lat got=%0d exp=2", lat); end
  endtask

  task automatic test_div;
    int lat; logic [31:0] res; logic [4:0] t;
    run_op(3'd4, 32'hFFFFFFEC, 32'd3, 5'd10, lat, res, t);
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_lat got=%0d exp=33", lat); end
    checks++; if (res !== 32'hFFFFFFFA) begin failures++; $display("FAIL div_neg got=%h exp=FFFFFFFA", res); end
    checks++; if (t !== 5'd10) begin failures++; $display("FAIL div_rd got=%0d exp=10", t); end
    run_op(3'd6, 32'hFFFFFFEC, 32'd3, 5'd11, lat, res, t);
    checks++; if (res !== 32'hFFFFFFFE) begin failures++; $display("FAIL rem_neg got=%h exp=FFFFFFFE", res); end
    run_op(3'd4, 32'd20, 32'hFFFFFFFD, 5'd12, lat, res, t);
    checks++; if (res !== 32'hFFFFFFFA) begin failures++; $display("FAIL div_negdivisor got=%h exp=FFFFFFFA", res); end
    run_op(3'd6, 32'd20, 32'hFFFFFFFD, 5'd13, lat, res, t);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL rem_negdivisor got=%h exp=2", res); end
    run_op(3'd5, 32'd100, 32'd7, 5'd14, lat, res, t);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=E", res); end
    run_op(3'd7, 32'hFFFFFFFF, 32'd16, 5'd15, lat, res, t);
    checks++; if (res !== 32'd15) begin failures++; $display("FAIL remu_big got=%h exp=F", res); end
  endtask

  task automatic test_div_bits4;
    int lat;
    @(negedge clk);
    valid4 = 1'b1; op = 3'd4; rs1 = 32'hFFFFFFEC; rs2 = 32'd3; rd = 5'd20;
    @(posedge clk); #1;
    valid4 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (valid4_o) begin lat = i; break; end
    end
    checks++; if (lat !== 9) begin failures++; $display("FAIL div4_lat got=%0d exp=9", lat); end
    checks++; if (result4_o !== 32'hFFFFFFFA) begin failures++; $display("FAIL div4_res got=%h exp=FFFFFFFA", result4_o); end
    checks++; if (rd4_o !== 5'd20) begin failures++; $display("FAIL div4_rd got=%0d exp=20", rd4_o); end
  endtask

  task automatic test_special;
    int lat; logic [31:0] res; logic [4:0] t;
    run_op(3'd5, 32'd5, 32'd0, 5'd21, lat, res, t);
    checks++; if (lat !== 1) begin failures++; $display("FAIL divu0_lat got=%0d exp=1", lat); end
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0 got=%h exp=FFFFFFFF", res); end
    run_op(3'd7, 32'd5, 32'd0, 5'd22, lat, res, t);
    checks++; if (res !== 32'd5) begin failures++; $display("FAIL remu0 got=%h exp=5", res); end
    run_op(3'd4, 32'hFFFFFFF9, 32'd0, 5'd23, lat, res, t);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0 got=%h exp=FFFFFFFF", res); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd24, lat, res, t);
    checks++; if (lat !== 1) begin failures++; $display("FAIL ovf_lat got=%0d exp=1", lat); end
    checks++; if (res !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", res); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd25, lat, res, t);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=0", res); end
  endtask

  task automatic test_flush;
    int lat; int seen; logic [31:0] res; logic [4:0] t;
    drive(3'd4, 32'd1000, 32'd7, 5'd30);
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (valid_o) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_novalid got=%0d exp=0", seen); end
    checks++; if (rd_o !== 5'd25) begin failures++; $display("FAIL flush_rdhold got=%0d exp=25", rd_o); end
    run_op(3'd0, 32'd6, 32'd7, 5'd9, lat, res, t);
    checks++; if (res !== 32'd42) begin failures++; $display("FAIL flush_next_res got=%h exp=2A", res); end
    checks++; if (t !== 5'd9) begin failures++; $display("FAIL flush_next_rd got=%0d exp=9", t); end
    @(negedge clk); valid = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; rd = 5'd8;
    @(posedge clk); #1; valid = 1'b0; flush = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_with_valid got=%b exp=0", busy_o); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (valid_o) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_with_valid_out got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] res; logic [4:0] t;
    run_op(3'd0, 32'd3, 32'd4, 5'd3, lat, res, t);
    checks++; if (res !== 32'd12) begin failures++; $display("FAIL b2b_first_res got=%h exp=C", res); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ready_o); end
    valid = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd4;
    @(posedge clk); #1; valid = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy_o); end
    wait_result(lat, res, t);
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_lat got=%0d exp=33", lat); end
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL b2b_second_res got=%h exp=E", res); end
    checks++; if (t !== 5'd4) begin failures++; $display("FAIL b2b_second_rd got=%0d exp=4", t); end
  endtask

  task automatic test_reset_mid_div;
    drive(3'd4, 32'd500, 32'd9, 5'd17);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready_o); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", result_o); end
    checks++; if (rd_o !== 5'd0) begin failures++; $display("FAIL rst_mid_rd got=%0d exp=0", rd_o); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", valid_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; valid4 = 1'b0; flush = 1'b0;
    op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0;
    repeat (3) @(posedge clk);
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_bits4();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
